// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-ported memory between the RV32I fetch unit and the load/store unit.
// Each access runs IDLE -> FETCH/DATA -> RESP; bad requests skip memory and go straight to RESP.
module rv32i_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_starve_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic        r_is_store;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;

  logic        r_if_valid;
  logic        r_if_err;
  logic [31:0] r_if_rdata;
  logic        r_ls_done;
  logic        r_ls_err;
  logic [31:0] r_ls_rdata;

  logic        w_fetch_win;
  logic        w_data_win;
  logic        w_if_misalign;
  logic        w_ls_illegal;
  logic        w_ls_misalign;
  logic        w_ls_bad;
  logic        w_ack;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;

  // Data normally wins; fetch only preempts once it has been passed over STARVE_LIMIT times.
  assign w_fetch_win   = if_req && (!ls_req || (r_starve_cnt == LIMIT));
  assign w_data_win    = ls_req && !w_fetch_win;
  assign w_if_misalign = |if_addr[1:0];
  assign w_ls_bad      = w_ls_illegal || w_ls_misalign;
  assign w_ack         = ((r_state == S_FETCH) || (r_state == S_DATA)) && r_mem_req && mem_ack;

  always_comb begin
    w_ls_illegal  = 1'b0;
    w_ls_misalign = 1'b0;
    if (ls_we) begin
      w_ls_illegal = ls_funct3[2] || (ls_funct3[1:0] == 2'b11);
    end else begin
      w_ls_illegal = (ls_funct3 == 3'b011) || (ls_funct3[2:1] == 2'b11);
    end
    if (ls_funct3[1:0] == 2'b01) begin
      w_ls_misalign = ls_addr[0];
    end else if (ls_funct3[1:0] == 2'b10) begin
      w_ls_misalign = |ls_addr[1:0];
    end
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (ls_we) begin
      case (ls_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ls_addr[1:0];
          w_wdata = {4{ls_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = ls_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{ls_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ls_wdata;
        end
      endcase
    end
  end

  // Right-justify the addressed byte/half so extension only looks at the low bits.
  always_comb begin
    w_shifted  = mem_rdata >> {r_lane, 3'b000};
    w_load_ext = mem_rdata;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_ext = {24'h0, w_shifted[7:0]};
      3'b101:  w_load_ext = {16'h0, w_shifted[15:0]};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fetch_win) begin
          w_next_state = w_if_misalign ? S_RESP : S_FETCH;
        end else if (w_data_win) begin
          w_next_state = w_ls_bad ? S_RESP : S_DATA;
        end
      end
      S_FETCH, S_DATA: begin
        if (w_ack) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_data_win && if_req) begin
        if (r_starve_cnt != LIMIT) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else if (w_fetch_win || !if_req) begin
        r_starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3   <= '0;
      r_lane     <= '0;
      r_is_store <= 1'b0;
    end else if ((r_state == S_IDLE) && w_data_win) begin
      r_funct3   <= ls_funct3;
      r_lane     <= ls_addr[1:0];
      r_is_store <= ls_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_fetch_win && !w_if_misalign) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= {if_addr[31:2], 2'b00};
        r_mem_be    <= 4'b1111;
        r_mem_wdata <= '0;
      end else if (w_data_win && !w_ls_bad) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= ls_we;
        r_mem_addr  <= {ls_addr[31:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
      end
    end else if (w_ack) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end
  end

  // Completion outputs are loaded on the edge entering RESP, so they pulse for exactly that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= '0;
      r_ls_done  <= 1'b0;
      r_ls_err   <= 1'b0;
      r_ls_rdata <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= '0;
      r_ls_done  <= 1'b0;
      r_ls_err   <= 1'b0;
      r_ls_rdata <= '0;
      if (r_state == S_IDLE) begin
        if (w_fetch_win && w_if_misalign) begin
          r_if_valid <= 1'b1;
          r_if_err   <= 1'b1;
        end else if (w_data_win && w_ls_bad) begin
          r_ls_done <= 1'b1;
          r_ls_err  <= 1'b1;
        end
      end else if (w_ack) begin
        if (r_state == S_FETCH) begin
          r_if_valid <= 1'b1;
          r_if_rdata <= mem_rdata;
        end else begin
          r_ls_done  <= 1'b1;
          r_ls_rdata <= r_is_store ? 32'h0 : w_load_ext;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign if_valid  = r_if_valid;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign ls_done   = r_ls_done;
  assign ls_err    = r_ls_err;
  assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: byte-level memory reference model, random-latency
// memory responder, per-requester expectation queues popped by an independent monitor.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_err;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [2:0]  ls_funct3 = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        ls_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  rv32i_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        chkData;
  } exp_t;

  exp_t        ifExpQ[$];
  exp_t        lsExpQ[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  refBytes[int unsigned];
  logic [31:0] memWords[int unsigned];
  int          fixedLat = -1;
  int          curLat = 0;
  int          waitCnt = 0;
  bit          lateAck = 1'b0;
  int          memReqRises = 0;
  bit          logGrants = 1'b0;
  logic [7:0]  grantLog[$];
  logic        prevMemReq = 1'b0;

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [7:0] refByte(input logic [31:0] a);
    logic [31:0] w;
    if (refBytes.exists(a)) return refBytes[a];
    w = initWord({a[31:2], 2'b00});
    w = w >> (8 * a[1:0]);
    return w[7:0];
  endfunction

  function automatic logic [31:0] refWord(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v = v | ({24'h0, refByte(a + i)} << (8 * i));
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: RV32I load/store semantics on a byte-addressed memory.
  task automatic modelLs(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
    int size;
    logic legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal || (a % size) != 0) begin
      e = '{32'h0, 1'b1, 1'b0};
    end else if (we) begin
      for (int i = 0; i < size; i++) refBytes[a + i] = wd[8*i +: 8];
      e = '{32'h0, 1'b0, 1'b1};
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | ({24'h0, refByte(a + i)} << (8 * i));
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
      e = '{v, 1'b0, 1'b1};
    end
  endtask

  // Issues one load/store; entered and left at posedge+1 with ls_req dropped on exit.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input bit useConst, input logic [31:0] cData,
                               input logic cErr, input int expWait);
    exp_t e;
    int waited;
    bit got;
    modelLs(we, f3, a, wd, e);
    if (useConst) e = '{cData, cErr, !cErr};
    lsExpQ.push_back(e);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = a; ls_wdata = wd;
    waited = 0; got = 1'b0;
    while (!got && waited < 200) begin
      @(negedge clk);
      waited++;
      if (ls_done) got = 1'b1;
    end
    if (!got) begin
      errors++;
      $display("[TB] FAIL ls timeout: actual=no ls_done required=ls_done addr=%h", a);
    end else if (expWait > 0) begin
      checkOutput("ls latency", waited, expWait);
    end
    @(posedge clk);
    #1;
    ls_req = 1'b0;
  endtask

  task automatic applyFetchStimulus(input logic [31:0] a, input int expWait);
    exp_t e;
    int waited;
    bit got;
    if (a[1:0] != 2'b00) e = '{32'h0, 1'b1, 1'b0};
    else                 e = '{refWord(a), 1'b0, 1'b1};
    ifExpQ.push_back(e);
    if_req = 1'b1; if_addr = a;
    waited = 0; got = 1'b0;
    while (!got && waited < 200) begin
      @(negedge clk);
      waited++;
      if (if_valid) got = 1'b1;
    end
    if (!got) begin
      errors++;
      $display("[TB] FAIL if timeout: actual=no if_valid required=if_valid addr=%h", a);
    end else if (expWait > 0) begin
      checkOutput("if latency", waited, expWait);
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic watchMem(input logic [31:0] eAddr, input logic [3:0] eBe, input logic [31:0] eWd,
                          input logic eWe, input bit chkWd);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (mem_req) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      $display("[TB] FAIL mem_req timeout: actual=0 required=1");
    end else begin
      checkOutput("mem_addr", mem_addr, eAddr);
      checkOutput("mem_be", {28'h0, mem_be}, {28'h0, eBe});
      checkOutput("mem_we", {31'h0, mem_we}, {31'h0, eWe});
      if (chkWd) checkOutput("mem_wdata", mem_wdata, eWd);
    end
  endtask

  task automatic runLsRandom(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      a = 32'h2000 + (($urandom_range(0, 1) == 1) ? ($urandom_range(0, 15) << 2) : $urandom_range(0, 63));
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0, 32'h0, 1'b0, 0);
    end
  endtask

  task automatic runIfRandom(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      a = 32'h1000 + ($urandom_range(0, 63) << 2);
      if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
      applyFetchStimulus(a, 0);
    end
  endtask

  // Memory responder: word-addressed store with byte enables, random or fixed ack latency.
  initial begin
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      if (lateAck) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end else if (mem_req && rst_n) begin
        if (waitCnt >= curLat) begin
          mem_ack = 1'b1;
          mem_rdata = memWords.exists(mem_addr) ? memWords[mem_addr] : initWord(mem_addr);
          if (mem_we) begin
            logic [31:0] w;
            w = mem_rdata;
            for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            memWords[mem_addr] = w;
          end
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
        curLat = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: pops an expectation on every completion pulse, data must be zero otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_valid) begin
        if (ifExpQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected if_valid: actual=1 required=0 at %0t", $time);
        end else begin
          e = ifExpQ.pop_front();
          checkOutput("if_err", {31'h0, if_err}, {31'h0, e.err});
          if (e.chkData) checkOutput("if_rdata", if_rdata, e.data);
        end
      end else begin
        checkOutput("if_rdata idle", if_rdata, 32'h0);
      end
      if (ls_done) begin
        if (lsExpQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected ls_done: actual=1 required=0 at %0t", $time);
        end else begin
          e = lsExpQ.pop_front();
          checkOutput("ls_err", {31'h0, ls_err}, {31'h0, e.err});
          if (e.chkData) checkOutput("ls_rdata", ls_rdata, e.data);
        end
      end else begin
        checkOutput("ls_rdata idle", ls_rdata, 32'h0);
      end
      if (mem_req && !prevMemReq) begin
        memReqRises++;
        if (logGrants) grantLog.push_back((!mem_we && mem_addr < 32'h2000) ? "F" : "D");
      end
      prevMemReq = mem_req;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0;
    bit seen;
    logic [7:0] expG;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("reset mem_be", {28'h0, mem_be}, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset if_valid", {31'h0, if_valid}, 32'h0);
    checkOutput("reset ls_done", {31'h0, ls_done}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] fetch with fixed ack latency");
    fixedLat = 2;
    fork
      applyFetchStimulus(32'h100, 5);
      watchMem(32'h100, 4'b1111, 32'h0, 1'b0, 1'b0);
    join
    fixedLat = -1;

    $display("[TB] byte loads with sign and zero extension");
    applyStimulus(1'b1, 3'b010, 32'h200, 32'h80FFFF00, 1'b1, 32'h0, 1'b0, 0);
    applyStimulus(1'b0, 3'b000, 32'h203, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 0);
    applyStimulus(1'b0, 3'b100, 32'h203, 32'h0, 1'b1, 32'h00000080, 1'b0, 0);

    $display("[TB] halfword store lanes");
    fork
      applyStimulus(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 1'b1, 32'h0, 1'b0, 0);
      watchMem(32'h300, 4'b1100, 32'hABCDABCD, 1'b1, 1'b1);
    join
    applyStimulus(1'b0, 3'b101, 32'h302, 32'h0, 1'b1, 32'h0000ABCD, 1'b0, 0);
    applyStimulus(1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    fork
      applyStimulus(1'b1, 3'b000, 32'h2003, 32'h000000A7, 1'b0, 32'h0, 1'b0, 0);
      watchMem(32'h2000, 4'b1000, 32'hA7A7A7A7, 1'b1, 1'b1);
    join

    $display("[TB] error requests bypass memory");
    r0 = memReqRises;
    applyStimulus(1'b0, 3'b010, 32'h401, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    applyStimulus(1'b1, 3'b011, 32'h400, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    applyStimulus(1'b0, 3'b001, 32'h2001, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    applyStimulus(1'b0, 3'b110, 32'h2000, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    applyFetchStimulus(32'h102, 2);
    checkOutput("no mem access on errors", memReqRises, r0);

    $display("[TB] starvation limit");
    grantLog.delete();
    logGrants = 1'b1;
    fork
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'b010, 32'h2000 + 4 * i, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      for (int j = 0; j < 2; j++) applyFetchStimulus(32'h1000 + 4 * j, 0);
    join
    logGrants = 1'b0;
    checkOutput("grant count", grantLog.size(), 10);
    for (int i = 0; i < 10 && i < grantLog.size(); i++) begin
      expG = (i % 5 == 4) ? "F" : "D";
      checkOutput($sformatf("grant order %0d", i), {24'h0, grantLog[i]}, {24'h0, expG});
    end

    $display("[TB] random traffic");
    fork
      runLsRandom(80);
      runIfRandom(50);
    join

    $display("[TB] reset during pending access");
    fixedLat = 30;
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h2004;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    checkOutput("mem_req before reset", {31'h0, mem_req}, 32'h1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mem_req async drop", {31'h0, mem_req}, 32'h0);
    ls_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    lateAck = 1'b1;
    @(posedge clk);
    #1;
    lateAck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mem_req after late ack", {31'h0, mem_req}, 32'h0);
    fixedLat = -1;
    applyStimulus(1'b0, 3'b010, 32'h2004, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    applyFetchStimulus(32'h1010, 0);

    repeat (5) @(posedge clk);
    checkOutput("if queue drained", ifExpQ.size(), 0);
    checkOutput("ls queue drained", lsExpQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
